// File: rtl/nand_io_pkg.sv
// Shared NAND IO definitions: direction encoding, burst FSM states and
// default strobe timings used by the master sequencer.
package nand_io_pkg;

    localparam logic IO_WRITE = 1'b0;
    localparam logic IO_READ  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOW,
        HIGH,
        DONE
    } io_burst_state_t;

    // Default phase lengths in clk cycles
    localparam int unsigned T_WP  = 2;
    localparam int unsigned T_WH  = 2;
    localparam int unsigned T_REA = 3;
    localparam int unsigned T_REH = 2;

endpackage

// File: rtl/nand_phase_timer.sv
// Loadable down-counter timing one strobe phase; expire is high on the
// last cycle of a phase loaded with (length - 1).
module nand_phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/nand_io_burst.sv
// Burst NAND data IO: moves burst_len words over the pad bus, generating
// WE#/RE# with programmable low/high phase lengths.
module nand_io_burst
    import nand_io_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned LEN_W  = 12,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic              io_type,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [CNT_W-1:0]  t_low,
    input  logic [CNT_W-1:0]  t_high,
    input  logic              abort,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    output logic              strobe_n,
    output logic              busy,
    output logic              done
);

    io_burst_state_t  state, state_next;
    logic             dir_q;
    logic [LEN_W-1:0] remaining;
    logic [CNT_W-1:0] tl_q, th_q;
    logic [CNT_W-1:0] tl_m1, th_m1, load_val;
    logic             tmr_load, tmr_expire;
    logic             go, accept, capture;

    // Phase lengths are held as (length - 1); zero lengths behave as one
    always_comb begin
        tl_m1 = (t_low  == '0) ? '0 : t_low  - CNT_W'(1);
        th_m1 = (t_high == '0) ? '0 : t_high - CNT_W'(1);
        if (state != IDLE) begin
            tl_m1 = tl_q;
            th_m1 = th_q;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        go         = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    go = 1'b1;
                    if (burst_len == '0) begin
                        state_next = DONE;
                    end else if (io_type == IO_WRITE) begin
                        state_next = FETCH;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            FETCH: begin
                if (wr_valid) begin
                    accept     = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    if (remaining == '0) begin
                        state_next = DONE;
                    end else if (dir_q == IO_WRITE) begin
                        state_next = FETCH;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_next = IDLE;
            accept     = 1'b0;
        end
        capture  = (state == LOW) && (state_next == HIGH) && (dir_q == IO_READ);
        tmr_load = ((state_next == LOW)  && (state != LOW)) ||
                   ((state_next == HIGH) && (state != HIGH));
        load_val = (state_next == HIGH) ? th_m1 : tl_m1;
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (!nreset) begin
            dir_q     <= IO_WRITE;
            remaining <= '0;
            tl_q      <= '0;
            th_q      <= '0;
            wr_ready  <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            bus_out   <= '0;
            bus_oe    <= 1'b0;
            strobe_n  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            if (go) begin
                dir_q     <= io_type;
                remaining <= burst_len;
                tl_q      <= tl_m1;
                th_q      <= th_m1;
            end else if (state == LOW && state_next == HIGH) begin
                remaining <= remaining - LEN_W'(1);
            end
            if (accept) begin
                bus_out <= wr_data;
            end
            if (state_next == IDLE || state_next == DONE) begin
                bus_oe <= 1'b0;
            end else if (accept) begin
                bus_oe <= 1'b1;
            end
            if (capture) begin
                rd_data <= bus_in;
            end
            rd_valid <= capture;
            wr_ready <= (state_next == FETCH);
            strobe_n <= (state_next != LOW);
            busy     <= (state_next != IDLE);
            done     <= (state_next == DONE);
        end
    end

    nand_phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .nreset   (nreset),
        .load     (tmr_load),
        .load_val (load_val),
        .expire   (tmr_expire)
    );

endmodule
